// File: rtl/sha256_round_tail_58_63_if.sv
// Handshake and data bundle for the SHA-256 round 58..63 tail.
// master: the upstream pipeline side; slave: the round tail itself.
interface sha256_round_tail_58_63_if;
    logic         start;
    logic [255:0] state_in;
    logic [255:0] h_init;
    logic [31:0]  w_in;
    logic         w_valid;
    logic         w_ready;
    logic         busy;
    logic [5:0]   round_idx;
    logic [255:0] state_out;
    logic [255:0] digest;
    logic         digest_valid;
    logic         done;

    modport master (
        output start, state_in, h_init, w_in, w_valid,
        input  w_ready, busy, round_idx, state_out, digest, digest_valid, done
    );

    modport slave (
        input  start, state_in, h_init, w_in, w_valid,
        output w_ready, busy, round_idx, state_out, digest, digest_valid, done
    );
endinterface

// File: rtl/sha256_round_tail_58_63.sv
// Iterative SHA-256 compression tail: rounds 58..63, one round per accepted
// message word, followed by the chaining-value add that forms the digest.
module sha256_round_tail_58_63 (
    input logic                      CLK,
    input logic                      RST,
    sha256_round_tail_58_63_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFinal = 2'd2
    } state_e;

    localparam logic [2:0] LastCnt    = 3'd5;
    localparam logic [5:0] FirstRound = 6'd58;

    state_e       fsm_q, fsm_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [255:0] work_q, work_d;
    logic [255:0] hval_q, hval_d;
    logic [255:0] digest_q, digest_d;
    logic         digest_valid_q, digest_valid_d;
    logic         done_q, done_d;

    logic         load;
    logic         handshake;
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  k_t;
    logic [31:0]  t1, t2;
    logic [255:0] digest_sum;

    // Rotations are fixed wiring, so write them as concatenations.
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    assign load      = (fsm_q == StIdle) && bus.start;
    assign handshake = (fsm_q == StRun) && bus.w_valid;

    assign {a, b, c, d, e, f, g, h} = work_q;

    // Round constant for the current round, indexed by the round counter.
    always_comb begin
        k_t = 32'h0;
        unique case (cnt_q)
            3'd0:    k_t = 32'h84c87814;
            3'd1:    k_t = 32'h8cc70208;
            3'd2:    k_t = 32'h90befffa;
            3'd3:    k_t = 32'ha4506ceb;
            3'd4:    k_t = 32'hbef9a3f7;
            3'd5:    k_t = 32'hc67178f2;
            default: k_t = 32'h0;
        endcase
    end

    // One SHA-256 round on the current working registers.
    always_comb begin
        t1 = h + big_sigma1(e) + ch(e, f, g) + k_t + bus.w_in;
        t2 = big_sigma0(a) + maj(a, b, c);
    end

    // Per-word chaining add of the working state and the latched H.
    always_comb begin
        digest_sum = '0;
        for (int i = 0; i < 8; i++) begin
            digest_sum[i*32 +: 32] = work_q[i*32 +: 32] + hval_q[i*32 +: 32];
        end
    end

    // FSM next state: words are only consumed in RUN, FINAL lasts one cycle.
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            StIdle:  if (bus.start) fsm_d = StRun;
            StRun:   if (handshake && (cnt_q == LastCnt)) fsm_d = StFinal;
            StFinal: fsm_d = StIdle;
            default: fsm_d = StIdle;
        endcase
    end

    // Working state, H and counter: reload on start, advance on each handshake.
    always_comb begin
        work_d = work_q;
        hval_d = hval_q;
        cnt_d  = cnt_q;
        if (load) begin
            work_d = bus.state_in;
            hval_d = bus.h_init;
            cnt_d  = 3'd0;
        end else if (handshake) begin
            work_d = {t1 + t2, a, b, c, d + t1, e, f, g};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    // Result registers: digest is captured in FINAL and held until the next load.
    always_comb begin
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        done_d         = 1'b0;
        if (load) begin
            digest_valid_d = 1'b0;
        end
        if (fsm_q == StFinal) begin
            digest_d       = digest_sum;
            digest_valid_d = 1'b1;
            done_d         = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Datapath registers: working state, chaining value, round counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            work_q <= '0;
            hval_q <= '0;
            cnt_q  <= 3'd0;
        end else begin
            work_q <= work_d;
            hval_q <= hval_d;
            cnt_q  <= cnt_d;
        end
    end

    // Result registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            done_q         <= done_d;
        end
    end

    assign bus.w_ready      = (fsm_q == StRun);
    assign bus.busy         = (fsm_q == StRun) || (fsm_q == StFinal);
    assign bus.round_idx    = (fsm_q == StRun) ? (FirstRound + {3'b000, cnt_q}) : 6'd0;
    assign bus.state_out    = work_q;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.done         = done_q;
endmodule
